// File: rtl/exc_collector.sv
// Exception collector for the MIPS memory/commit stage: picks the highest-priority source and hands it to CP0.
// Optional committed-exception counter is built only when EXC_COUNT_EN is defined.
module exc_collector #(
   parameter int NUM_SRC = 4,
   parameter int CODE_W  = 5,
   parameter int SRC_W   = $clog2(NUM_SRC)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       instr_valid,
   input  logic [NUM_SRC-1:0]         src_valid,
   input  logic [NUM_SRC*CODE_W-1:0]  src_code,
   input  logic                       stall,
   input  logic                       flush,
   input  logic                       cp0_ready,
   output logic                       pending_exc,
   output logic                       exc_commit,
   output logic [CODE_W-1:0]          exc_code,
   output logic [SRC_W-1:0]           exc_src,
   output logic [31:0]                exc_count
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_COMMIT = 2'd2
   } state_t;

   state_t              state_q;
   logic                commit_q;
   logic [CODE_W-1:0]   code_q;
   logic [SRC_W-1:0]    src_q;
   logic [SRC_W-1:0]    sel_idx_s;
   logic [CODE_W-1:0]   sel_code_s;
   logic                capture_s;

   // Lowest set index wins: scan downward so the last hit is the highest-priority source.
   always_comb begin
      sel_idx_s  = {SRC_W{1'b0}};
      sel_code_s = {CODE_W{1'b0}};
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (src_valid[i]) begin
            sel_idx_s  = SRC_W'(i);
            sel_code_s = src_code[i*CODE_W +: CODE_W];
         end else begin
            sel_idx_s  = sel_idx_s;
            sel_code_s = sel_code_s;
         end
      end
   end

   assign capture_s   = instr_valid && (|src_valid) && !stall && !flush;
   assign pending_exc = (state_q != S_IDLE) || (instr_valid && (|src_valid));

   // Collector FSM with registered commit pulse and captured code/source.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         commit_q <= 1'b0;
         code_q   <= {CODE_W{1'b0}};
         src_q    <= {SRC_W{1'b0}};
      end else begin
         case (state_q)
            S_IDLE: begin
               if (capture_s) begin
                  code_q <= sel_code_s;
                  src_q  <= sel_idx_s;
                  if (cp0_ready) begin
                     state_q  <= S_COMMIT;
                     commit_q <= 1'b1;
                  end else begin
                     state_q  <= S_WAIT;
                     commit_q <= 1'b0;
                  end
               end else begin
                  state_q  <= S_IDLE;
                  commit_q <= 1'b0;
               end
            end
            S_WAIT: begin
               // flush outranks cp0_ready so a squashed instruction never reaches CP0
               if (flush) begin
                  state_q  <= S_IDLE;
                  commit_q <= 1'b0;
               end else if (cp0_ready) begin
                  state_q  <= S_COMMIT;
                  commit_q <= 1'b1;
               end else begin
                  state_q  <= S_WAIT;
                  commit_q <= 1'b0;
               end
            end
            S_COMMIT: begin
               state_q  <= S_IDLE;
               commit_q <= 1'b0;
            end
            default: begin
               state_q  <= S_IDLE;
               commit_q <= 1'b0;
            end
         endcase
      end
   end

   assign exc_commit = commit_q;
   assign exc_code   = code_q;
   assign exc_src    = src_q;

`ifdef EXC_COUNT_EN
   logic [31:0] count_q;
   logic [31:0] count_d;

   // Saturating count of COMMIT cycles.
   always_comb begin
      count_d = count_q;
      if (commit_q && (count_q != 32'hFFFF_FFFF)) begin
         count_d = count_q + 32'd1;
      end else begin
         count_d = count_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= 32'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign exc_count = count_q;
`else
   assign exc_count = 32'd0;
`endif

endmodule

// File: tb/tb_exc_collector.sv
// Directed self-checking bench for exc_collector (NUM_SRC=4, CODE_W=5).
module tb_exc_collector;

   localparam int NUM_SRC = 4;
   localparam int CODE_W  = 5;
   localparam int SRC_W   = 2;

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      instr_valid;
   logic [NUM_SRC-1:0]        src_valid;
   logic [NUM_SRC*CODE_W-1:0] src_code;
   logic                      stall;
   logic                      flush;
   logic                      cp0_ready;
   logic                      pending_exc;
   logic                      exc_commit;
   logic [CODE_W-1:0]         exc_code;
   logic [SRC_W-1:0]          exc_src;
   logic [31:0]               exc_count;

   int checks = 0;
   int errors = 0;
   int commits_expected = 0;

   exc_collector #(.NUM_SRC(NUM_SRC), .CODE_W(CODE_W)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .src_valid(src_valid),
      .src_code(src_code), .stall(stall), .flush(flush), .cp0_ready(cp0_ready),
      .pending_exc(pending_exc), .exc_commit(exc_commit), .exc_code(exc_code),
      .exc_src(exc_src), .exc_count(exc_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      instr_valid = 1'b0;
      src_valid   = 4'b0000;
      src_code    = 20'h00000;
      stall       = 1'b0;
      flush       = 1'b0;
      cp0_ready   = 1'b0;
   endtask

   function automatic logic [31:0] exp_count(input int n);
`ifdef EXC_COUNT_EN
      return 32'(n);
`else
      return 32'd0;
`endif
   endfunction

   initial begin
      idle_inputs();
      rst = 1'b1;
      #2;
      chk("reset_commit", {31'd0, exc_commit}, 32'd0);
      chk("reset_code", {27'd0, exc_code}, 32'd0);
      chk("reset_src", {30'd0, exc_src}, 32'd0);
      chk("reset_pending", {31'd0, pending_exc}, 32'd0);
      chk("reset_count", exc_count, 32'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Priority select: sources 3 and 1 set, source 1 wins
      instr_valid = 1'b1;
      src_valid   = 4'b1010;
      src_code    = {5'h0C, 5'h11, 5'h04, 5'h1F};
      cp0_ready   = 1'b1;
      #1;
      chk("prio_pending_capture", {31'd0, pending_exc}, 32'd1);
      chk("prio_commit_early", {31'd0, exc_commit}, 32'd0);
      tick();
      idle_inputs();
      #1;
      chk("prio_commit", {31'd0, exc_commit}, 32'd1);
      chk("prio_src", {30'd0, exc_src}, 32'd1);
      chk("prio_code", {27'd0, exc_code}, 32'h04);
      chk("prio_pending_commit", {31'd0, pending_exc}, 32'd1);
      commits_expected++;
      tick();
      chk("prio_commit_drop", {31'd0, exc_commit}, 32'd0);
      chk("prio_pending_idle", {31'd0, pending_exc}, 32'd0);
      chk("prio_code_hold", {27'd0, exc_code}, 32'h04);

      // Backpressure: cp0_ready low for 3 cycles
      instr_valid = 1'b1;
      src_valid   = 4'b0100;
      src_code    = {5'h00, 5'h0D, 5'h00, 5'h00};
      cp0_ready   = 1'b0;
      tick();
      instr_valid = 1'b0;
      src_valid   = 4'b0000;
      #1;
      chk("bp_wait1_commit", {31'd0, exc_commit}, 32'd0);
      chk("bp_wait1_pending", {31'd0, pending_exc}, 32'd1);
      chk("bp_code", {27'd0, exc_code}, 32'h0D);
      chk("bp_src", {30'd0, exc_src}, 32'd2);
      tick();
      chk("bp_wait2_commit", {31'd0, exc_commit}, 32'd0);
      chk("bp_wait2_pending", {31'd0, pending_exc}, 32'd1);
      tick();
      chk("bp_wait3_commit", {31'd0, exc_commit}, 32'd0);
      chk("bp_wait3_pending", {31'd0, pending_exc}, 32'd1);
      cp0_ready = 1'b1;
      #1;
      chk("bp_ready_same_cycle", {31'd0, exc_commit}, 32'd0);
      tick();
      cp0_ready = 1'b0;
      #1;
      chk("bp_commit", {31'd0, exc_commit}, 32'd1);
      commits_expected++;
      tick();
      chk("bp_single_pulse", {31'd0, exc_commit}, 32'd0);
      chk("bp_pending_idle", {31'd0, pending_exc}, 32'd0);

      // Flush in WAIT beats cp0_ready
      instr_valid = 1'b1;
      src_valid   = 4'b0001;
      src_code    = {5'h00, 5'h00, 5'h00, 5'h07};
      cp0_ready   = 1'b0;
      tick();
      instr_valid = 1'b0;
      src_valid   = 4'b0000;
      flush       = 1'b1;
      cp0_ready   = 1'b1;
      #1;
      chk("flush_wait_pending", {31'd0, pending_exc}, 32'd1);
      tick();
      idle_inputs();
      #1;
      chk("flush_no_commit", {31'd0, exc_commit}, 32'd0);
      chk("flush_idle_pending", {31'd0, pending_exc}, 32'd0);
      chk("flush_code_hold", {27'd0, exc_code}, 32'h07);
      tick();
      chk("flush_no_commit_late", {31'd0, exc_commit}, 32'd0);

      // Stall blocks capture but pending still asserts
      instr_valid = 1'b1;
      src_valid   = 4'b0010;
      src_code    = {5'h00, 5'h00, 5'h15, 5'h00};
      stall       = 1'b1;
      cp0_ready   = 1'b1;
      #1;
      chk("stall_pending", {31'd0, pending_exc}, 32'd1);
      tick();
      chk("stall_no_commit", {31'd0, exc_commit}, 32'd0);
      chk("stall_code_hold", {27'd0, exc_code}, 32'h07);

      // instr_valid low masks everything
      instr_valid = 1'b0;
      src_valid   = 4'b1111;
      src_code    = {5'h01, 5'h02, 5'h03, 5'h05};
      stall       = 1'b0;
      #1;
      chk("invalid_pending", {31'd0, pending_exc}, 32'd0);
      tick();
      chk("invalid_no_commit", {31'd0, exc_commit}, 32'd0);
      chk("invalid_code_hold", {27'd0, exc_code}, 32'h07);
      chk("invalid_src_hold", {30'd0, exc_src}, 32'd0);

      // Back-to-back: continuous exception commits at T+1 and T+3
      instr_valid = 1'b1;
      src_valid   = 4'b1000;
      src_code    = {5'h0C, 5'h00, 5'h00, 5'h00};
      cp0_ready   = 1'b1;
      tick();
      chk("b2b_commit1", {31'd0, exc_commit}, 32'd1);
      chk("b2b_code", {27'd0, exc_code}, 32'h0C);
      chk("b2b_src", {30'd0, exc_src}, 32'd3);
      commits_expected++;
      tick();
      chk("b2b_gap", {31'd0, exc_commit}, 32'd0);
      tick();
      idle_inputs();
      #1;
      chk("b2b_commit2", {31'd0, exc_commit}, 32'd1);
      commits_expected++;
      tick();
      chk("b2b_end", {31'd0, exc_commit}, 32'd0);
      chk("count_after_commits", exc_count, exp_count(commits_expected));

      // Reset during WAIT discards the held exception
      instr_valid = 1'b1;
      src_valid   = 4'b0001;
      src_code    = {5'h00, 5'h00, 5'h00, 5'h0A};
      cp0_ready   = 1'b0;
      tick();
      idle_inputs();
      #1;
      chk("rst_wait_pending", {31'd0, pending_exc}, 32'd1);
      chk("rst_wait_code", {27'd0, exc_code}, 32'h0A);
      #1;
      cp0_ready = 1'b1;
      rst = 1'b1;
      #1;
      chk("rst_async_pending", {31'd0, pending_exc}, 32'd0);
      chk("rst_async_code", {27'd0, exc_code}, 32'd0);
      chk("rst_async_commit", {31'd0, exc_commit}, 32'd0);
      chk("rst_async_count", exc_count, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("rst_no_pulse", {31'd0, exc_commit}, 32'd0);
      chk("rst_src", {30'd0, exc_src}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/exc_collector.md
# exc_collector

Parametrised exception collector for the memory/commit stage of the MIPS pipeline. Gathers up to NUM_SRC per-instruction exception flags (address error, reserved instruction, overflow, TLB, ...), selects the highest-priority one, and holds it until CP0 can accept it. It then issues a single-cycle commit pulse with the exception code and source index. It also drives a combinational `pending_exc` that upstream stages use to suppress side effects.

## Interface
Parameters:
- NUM_SRC, 4: number of exception sources; index 0 has the highest priority.
- CODE_W, 5: width of each exception code (ExcCode field).
- SRC_W, $clog2(NUM_SRC): width of the source index (derived; NUM_SRC ≥ 2).

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- instr_valid  in  1  valid instruction present in the stage.
- src_valid  in  NUM_SRC  per-source exception flag for the current instruction.
- src_code  in  NUM_SRC*CODE_W  per-source code; source i is at bits [i*CODE_W +: CODE_W].
- stall  in  1  stage is stalled; no new capture this cycle.
- flush  in  1  pipeline flush; discards the current input and any held exception not yet committing.
- cp0_ready  in  1  CP0 can accept an exception.
- pending_exc  out  1  combinational; an exception is held or arriving.
- exc_commit  out  1  registered one-cycle pulse; exception delivered to CP0.
- exc_code  out  CODE_W  registered code of the last captured exception.
- exc_src  out  SRC_W  registered index of the last captured source.
- exc_count  out  32  committed-exception counter (see Configuration).

## Operation
- FSM states: IDLE, WAIT, COMMIT. Reset state: IDLE.
- Capture condition, evaluated only in IDLE: instr_valid && |src_valid && !stall && !flush.
  - On capture, latch exc_code and exc_src from the lowest set index of src_valid.
  - Next state is COMMIT if cp0_ready = 1, otherwise WAIT.
- WAIT:
  - flush = 1 → IDLE, no commit. flush takes priority over cp0_ready in the same cycle.
  - else cp0_ready = 1 → COMMIT.
  - else remain in WAIT.
  - stall has no effect.
- COMMIT:
  - exc_commit = 1.
  - Unconditional transition to IDLE; flush and stall are ignored.
  - No capture occurs in this cycle. An exception presented during COMMIT is captured in the following IDLE cycle only if it is still presented.
- exc_commit = (state == COMMIT). It is never high for two consecutive cycles.
- pending_exc = (state != IDLE) || (instr_valid && |src_valid). It does not depend on stall, flush or cp0_ready.
- exc_code and exc_src hold their last captured value after commit or flush. They change only on capture.
- Inputs with instr_valid = 0 are ignored entirely, regardless of src_valid.
- Reset values: state IDLE, exc_commit 0, exc_code 0, exc_src 0, exc_count 0. pending_exc is 0 while rst is high, provided instr_valid is also 0.

## Timing
- Best-case latency: capture at edge T with cp0_ready = 1 → exc_commit high during cycle T+1.
- Backpressure: with cp0_ready low, the exception waits in WAIT. The first edge that samples cp0_ready = 1 moves to COMMIT, and the pulse appears in the cycle after that edge.
- Minimum spacing between two commits is 2 cycles (COMMIT → IDLE → capture → COMMIT), giving commits at T+1 and T+3.
- exc_code and exc_src are valid from the cycle after capture and remain stable through COMMIT.
- pending_exc responds to inputs within the same cycle, with no registered delay.
- An asserted rst at any point forces IDLE immediately; any in-flight WAIT or COMMIT is discarded with no pulse.

## Configuration
- EXC_COUNT_EN defined:
  - exc_count is a 32-bit saturating counter that increments by 1 in each COMMIT cycle and holds at 32'hFFFF_FFFF.
  - Reset value is 0.
- EXC_COUNT_EN undefined:
  - exc_count is tied to 0 and no counter flops are generated.
  - All other behaviour is identical.

## Test plan
- Priority select: NUM_SRC = 4, instr_valid = 1, src_valid = 4'b1010, codes {3: 5'h0C, 1: 5'h04}, cp0_ready = 1 → next cycle exc_commit = 1, exc_src = 1, exc_code = 5'h04; pending_exc = 1 in the capture cycle.
- Backpressure: capture with cp0_ready = 0 held for 3 cycles, then 1 → state stays in WAIT, pending_exc = 1 throughout, and exactly one exc_commit pulse occurs one cycle after cp0_ready rises.
- Flush in WAIT: capture with cp0_ready = 0, then flush = 1 together with cp0_ready = 1 → no exc_commit, return to IDLE, exc_code retains the captured value.
- Stall and invalid inputs:
  - stall = 1 with src_valid ≠ 0 → no capture, while pending_exc = 1.
  - instr_valid = 0 with src_valid = 4'b1111 → pending_exc = 0, no capture.
- Back-to-back and reset:
  - Continuous exception with cp0_ready = 1 → commits at T+1 and T+3.
  - Asserting rst during WAIT → outputs return to 0 asynchronously.
  - With EXC_COUNT_EN, exc_count reads 2 after two commits and 0 after reset.
